pic_ctrl_regs: RTL and testbench

Clocked control-word register file of the 8259 PIC. It sits directly downstream of the bus read/write decoder and consumes its decoded write (type, nr, data). It runs the ICW1-ICW4 initialization sequence, holds the IMR and mode fields, and emits OCW2 command pulses to the priority resolver. It also returns the read-back word (IRR/ISR/IMR/poll) toward the data bus buffer.

---
 rtl/pic_pkg.sv | 61 ++++++
 rtl/pic_readback_mux.sv | 60 ++++++
 rtl/pic_ctrl_regs.sv | 245 ++++++++++++++++++++++++
 tb/tb_pic_ctrl_regs.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 control-word register file:
// init FSM states, ICW/OCW word numbers, control-bit positions, read sources.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT = 3'd0,
        ST_W_ICW2 = 3'd1,
        ST_W_ICW3 = 3'd2,
        ST_W_ICW4 = 3'd3,
        ST_READY  = 3'd4
    } pic_state_e;

    typedef enum logic [1:0] {
        RD_SRC_IRR  = 2'd0,
        RD_SRC_ISR  = 2'd1,
        RD_SRC_IMR  = 2'd2,
        RD_SRC_POLL = 2'd3
    } rd_src_e;

    localparam logic [1:0] ICW1_NR = 2'd0;
    localparam logic [1:0] ICW2_NR = 2'd1;
    localparam logic [1:0] ICW3_NR = 2'd2;
    localparam logic [1:0] ICW4_NR = 2'd3;
    localparam logic [1:0] OCW1_NR = 2'd0;
    localparam logic [1:0] OCW2_NR = 2'd1;
    localparam logic [1:0] OCW3_NR = 2'd2;

    localparam int unsigned ICW1_LTIM_BIT = 32'd3;
    localparam int unsigned ICW1_SNGL_BIT = 32'd1;
    localparam int unsigned ICW1_IC4_BIT  = 32'd0;
    localparam int unsigned ICW4_SFNM_BIT = 32'd4;
    localparam int unsigned ICW4_AEOI_BIT = 32'd1;

    localparam int unsigned OCW2_R_BIT    = 32'd7;
    localparam int unsigned OCW2_SL_BIT   = 32'd6;
    localparam int unsigned OCW2_EOI_BIT  = 32'd5;

    localparam int unsigned OCW3_ESMM_BIT = 32'd6;
    localparam int unsigned OCW3_SMM_BIT  = 32'd5;
    localparam int unsigned OCW3_P_BIT    = 32'd2;
    localparam int unsigned OCW3_RR_BIT   = 32'd1;
    localparam int unsigned OCW3_RIS_BIT  = 32'd0;

    // A pending poll outranks the A0 select; A0=0 then picks ISR or IRR via ris.
    function automatic rd_src_e rd_src_sel(input logic poll_pend,
                                           input logic a0,
                                           input logic ris);
        rd_src_e src;
        if (poll_pend) begin
            src = RD_SRC_POLL;
        end else if (a0) begin
            src = RD_SRC_IMR;
        end else if (ris) begin
            src = RD_SRC_ISR;
        end else begin
            src = RD_SRC_IRR;
        end
        return src;
    endfunction

endpackage

// File: rtl/pic_readback_mux.sv
// Registered read-back path: selects poll/IMR/ISR/IRR and returns it one
// cycle after rd_stb; rd_data holds between reads.
module pic_readback_mux
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_stb,
    input  logic       rd_a0,
    input  logic       poll_pend,
    input  logic       ris,
    input  logic [7:0] irr,
    input  logic [7:0] isr,
    input  logic [7:0] imr,
    input  logic [7:0] poll_word,
    output logic       poll_taken,
    output logic [7:0] rd_data,
    output logic       rd_vld,
    output logic       poll_ack
);

    rd_src_e    src_s;
    logic [7:0] word_s;
    logic [7:0] rd_data_r;
    logic       rd_vld_r;
    logic       poll_ack_r;

    // Source selection for the word captured on this read.
    always_comb begin
        src_s = rd_src_sel(poll_pend, rd_a0, ris);
        case (src_s)
            RD_SRC_POLL: word_s = poll_word;
            RD_SRC_IMR:  word_s = imr;
            RD_SRC_ISR:  word_s = isr;
            RD_SRC_IRR:  word_s = irr;
            default:     word_s = irr;
        endcase
    end

    // Read-back registers; data only updates on a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= 8'h00;
            rd_vld_r   <= 1'b0;
            poll_ack_r <= 1'b0;
        end else begin
            rd_vld_r   <= rd_stb;
            poll_ack_r <= rd_stb & poll_pend;
            if (rd_stb) begin
                rd_data_r <= word_s;
            end
        end
    end

    assign poll_taken = rd_stb & poll_pend;
    assign rd_data    = rd_data_r;
    assign rd_vld     = rd_vld_r;
    assign poll_ack   = poll_ack_r;

endmodule

// File: rtl/pic_ctrl_regs.sv
// 8259 control-word register file: ICW1-4 init sequence, IMR and mode
// fields, OCW2 command pulses and the read-back path.
module pic_ctrl_regs
    import pic_pkg::*;
#(
    parameter logic [7:0] RESET_IMR = 8'hFF,
    parameter logic [4:0] RESET_VEC = 5'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_stb,
    input  logic       wr_type,
    input  logic [1:0] wr_nr,
    input  logic [7:0] wr_data,
    input  logic       rd_stb,
    input  logic       rd_a0,
    input  logic [7:0] irr,
    input  logic [7:0] isr,
    input  logic [7:0] poll_word,
    output logic [7:0] imr,
    output logic [4:0] vector_base,
    output logic       ltim,
    output logic       sngl,
    output logic [7:0] cascade,
    output logic       aeoi,
    output logic       sfnm,
    output logic       init_done,
    output logic       init_clr,
    output logic       eoi_vld,
    output logic       eoi_spec,
    output logic [2:0] eoi_lvl,
    output logic       rot_vld,
    output logic       smm,
    output logic       poll_ack,
    output logic [7:0] rd_data,
    output logic       rd_vld
);

    pic_state_e state_r;
    pic_state_e state_s;

    logic       icw_wr_s;
    logic       ocw_wr_s;
    logic       icw1_s;
    logic       icw2_s;
    logic       icw3_s;
    logic       icw4_s;
    logic       ocw1_s;
    logic       ocw2_s;
    logic       ocw3_s;
    logic       poll_taken_s;

    logic [7:0] imr_r;
    logic [4:0] vector_base_r;
    logic       ltim_r;
    logic       sngl_r;
    logic       ic4_r;
    logic [7:0] cascade_r;
    logic       aeoi_r;
    logic       sfnm_r;
    logic       init_done_r;
    logic       init_clr_r;
    logic       eoi_vld_r;
    logic       eoi_spec_r;
    logic [2:0] eoi_lvl_r;
    logic       rot_vld_r;
    logic       smm_r;
    logic       ris_r;
    logic       poll_pend_r;

    // Write decode and init-sequence next state; ICW1 restarts from any state.
    always_comb begin
        icw_wr_s = wr_stb & wr_type;
        ocw_wr_s = wr_stb & ~wr_type & (state_r == ST_READY);
        icw1_s   = icw_wr_s & (wr_nr == ICW1_NR);
        ocw1_s   = ocw_wr_s & (wr_nr == OCW1_NR);
        ocw2_s   = ocw_wr_s & (wr_nr == OCW2_NR);
        ocw3_s   = ocw_wr_s & (wr_nr == OCW3_NR);
        icw2_s   = 1'b0;
        icw3_s   = 1'b0;
        icw4_s   = 1'b0;
        state_s  = state_r;
        if (icw1_s) begin
            state_s = ST_W_ICW2;
        end else if (icw_wr_s) begin
            case (state_r)
                ST_W_ICW2: begin
                    if (wr_nr == ICW2_NR) begin
                        icw2_s = 1'b1;
                        if (!sngl_r) begin
                            state_s = ST_W_ICW3;
                        end else if (ic4_r) begin
                            state_s = ST_W_ICW4;
                        end else begin
                            state_s = ST_READY;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_W_ICW3: begin
                    if (wr_nr == ICW3_NR) begin
                        icw3_s  = 1'b1;
                        state_s = ic4_r ? ST_W_ICW4 : ST_READY;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_W_ICW4: begin
                    if (wr_nr == ICW4_NR) begin
                        icw4_s  = 1'b1;
                        state_s = ST_READY;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: state_s = state_r;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Init FSM state register and its READY flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_UNINIT;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            init_done_r <= (state_s == ST_READY);
        end
    end

    // Initialization words: mode latches, vector base and cascade map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vector_base_r <= RESET_VEC;
            ltim_r        <= 1'b0;
            sngl_r        <= 1'b0;
            ic4_r         <= 1'b0;
            cascade_r     <= 8'h00;
            aeoi_r        <= 1'b0;
            sfnm_r        <= 1'b0;
        end else begin
            if (icw1_s) begin
                ltim_r <= wr_data[ICW1_LTIM_BIT];
                sngl_r <= wr_data[ICW1_SNGL_BIT];
                ic4_r  <= wr_data[ICW1_IC4_BIT];
                aeoi_r <= 1'b0;
                sfnm_r <= 1'b0;
            end else if (icw4_s) begin
                aeoi_r <= wr_data[ICW4_AEOI_BIT];
                sfnm_r <= wr_data[ICW4_SFNM_BIT];
            end
            if (icw2_s) begin
                vector_base_r <= wr_data[7:3];
            end
            if (icw3_s) begin
                cascade_r <= wr_data;
            end
        end
    end

    // Operational state: mask, special mask mode, read select and poll request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imr_r       <= RESET_IMR;
            smm_r       <= 1'b0;
            ris_r       <= 1'b0;
            poll_pend_r <= 1'b0;
        end else if (icw1_s) begin
            imr_r       <= 8'h00;
            smm_r       <= 1'b0;
            ris_r       <= 1'b0;
            poll_pend_r <= 1'b0;
        end else begin
            if (ocw1_s) begin
                imr_r <= wr_data;
            end
            if (ocw3_s && wr_data[OCW3_RR_BIT]) begin
                ris_r <= wr_data[OCW3_RIS_BIT];
            end
            if (ocw3_s && wr_data[OCW3_ESMM_BIT]) begin
                smm_r <= wr_data[OCW3_SMM_BIT];
            end
            // A new poll request wins over the one being consumed this cycle.
            if (ocw3_s && wr_data[OCW3_P_BIT]) begin
                poll_pend_r <= 1'b1;
            end else if (poll_taken_s) begin
                poll_pend_r <= 1'b0;
            end
        end
    end

    // Single-cycle command pulses toward the priority resolver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_clr_r <= 1'b0;
            eoi_vld_r  <= 1'b0;
            eoi_spec_r <= 1'b0;
            eoi_lvl_r  <= 3'd0;
            rot_vld_r  <= 1'b0;
        end else begin
            init_clr_r <= icw1_s;
            eoi_vld_r  <= ocw2_s & wr_data[OCW2_EOI_BIT];
            eoi_spec_r <= ocw2_s & wr_data[OCW2_SL_BIT];
            eoi_lvl_r  <= ocw2_s ? wr_data[2:0] : 3'd0;
            rot_vld_r  <= ocw2_s & wr_data[OCW2_R_BIT];
        end
    end

    pic_readback_mux u_readback (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_stb     (rd_stb),
        .rd_a0      (rd_a0),
        .poll_pend  (poll_pend_r),
        .ris        (ris_r),
        .irr        (irr),
        .isr        (isr),
        .imr        (imr_r),
        .poll_word  (poll_word),
        .poll_taken (poll_taken_s),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .poll_ack   (poll_ack)
    );

    assign imr         = imr_r;
    assign vector_base = vector_base_r;
    assign ltim        = ltim_r;
    assign sngl        = sngl_r;
    assign cascade     = cascade_r;
    assign aeoi        = aeoi_r;
    assign sfnm        = sfnm_r;
    assign init_done   = init_done_r;
    assign init_clr    = init_clr_r;
    assign eoi_vld     = eoi_vld_r;
    assign eoi_spec    = eoi_spec_r;
    assign eoi_lvl     = eoi_lvl_r;
    assign rot_vld     = rot_vld_r;
    assign smm         = smm_r;

endmodule

// File: tb/tb_pic_ctrl_regs.sv
// Directed-vector bench for pic_ctrl_regs with hand-computed expectations.
module tb_pic_ctrl_regs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_stb = 1'b0;
    logic       wr_type = 1'b0;
    logic [1:0] wr_nr = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_stb = 1'b0;
    logic       rd_a0 = 1'b0;
    logic [7:0] irr = 8'h00;
    logic [7:0] isr = 8'h00;
    logic [7:0] poll_word = 8'h00;
    logic [7:0] imr;
    logic [4:0] vector_base;
    logic       ltim;
    logic       sngl;
    logic [7:0] cascade;
    logic       aeoi;
    logic       sfnm;
    logic       init_done;
    logic       init_clr;
    logic       eoi_vld;
    logic       eoi_spec;
    logic [2:0] eoi_lvl;
    logic       rot_vld;
    logic       smm;
    logic       poll_ack;
    logic [7:0] rd_data;
    logic       rd_vld;

    int vectors = 0;
    int miscompares = 0;

    pic_ctrl_regs dut (
        .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .wr_type(wr_type),
        .wr_nr(wr_nr), .wr_data(wr_data), .rd_stb(rd_stb), .rd_a0(rd_a0),
        .irr(irr), .isr(isr), .poll_word(poll_word), .imr(imr),
        .vector_base(vector_base), .ltim(ltim), .sngl(sngl), .cascade(cascade),
        .aeoi(aeoi), .sfnm(sfnm), .init_done(init_done), .init_clr(init_clr),
        .eoi_vld(eoi_vld), .eoi_spec(eoi_spec), .eoi_lvl(eoi_lvl),
        .rot_vld(rot_vld), .smm(smm), .poll_ack(poll_ack),
        .rd_data(rd_data), .rd_vld(rd_vld)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    // One-cycle write; returns at the falling edge after the capturing edge.
    task automatic wr(input logic t, input logic [1:0] nr, input logic [7:0] d);
        @(negedge clk);
        wr_stb = 1'b1; wr_type = t; wr_nr = nr; wr_data = d;
        @(negedge clk);
        wr_stb = 1'b0;
    endtask

    task automatic rd(input logic a0);
        @(negedge clk);
        rd_stb = 1'b1; rd_a0 = a0;
        @(negedge clk);
        rd_stb = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_imr", imr, 8'hFF);
        check_val("rst_vec", {3'd0, vector_base}, 8'h00);
        check_val("rst_init_done", {7'd0, init_done}, 8'h00);
        check_val("rst_rd_vld", {7'd0, rd_vld}, 8'h00);
        rst_n = 1'b1;
        idle();

        // OCW1 before any ICW1 must be ignored
        wr(1'b0, 2'd0, 8'h5A);
        check_val("uninit_ocw1_imr", imr, 8'hFF);

        // Single, ICW4 needed: ICW1 13, ICW2 48, ICW4 03
        wr(1'b1, 2'd0, 8'h13);
        check_val("icw1_init_clr", {7'd0, init_clr}, 8'h01);
        check_val("icw1_imr", imr, 8'h00);
        check_val("icw1_sngl", {7'd0, sngl}, 8'h01);
        idle();
        check_val("init_clr_one_cycle", {7'd0, init_clr}, 8'h00);
        wr(1'b1, 2'd1, 8'h48);
        check_val("icw2_vec", {3'd0, vector_base}, 8'h09);
        check_val("icw2_not_done", {7'd0, init_done}, 8'h00);
        wr(1'b1, 2'd3, 8'h03);
        check_val("icw4_done", {7'd0, init_done}, 8'h01);
        check_val("icw4_aeoi", {7'd0, aeoi}, 8'h01);

        // Cascade, no ICW4: ICW1 10, ICW2 20, stray ICW4, ICW3 04
        wr(1'b1, 2'd0, 8'h10);
        check_val("icw1b_aeoi_clr", {7'd0, aeoi}, 8'h00);
        check_val("icw1b_not_done", {7'd0, init_done}, 8'h00);
        wr(1'b1, 2'd1, 8'h20);
        check_val("icw2b_vec", {3'd0, vector_base}, 8'h04);
        wr(1'b1, 2'd3, 8'h03);
        check_val("stray_icw4_done", {7'd0, init_done}, 8'h00);
        check_val("stray_icw4_aeoi", {7'd0, aeoi}, 8'h00);
        wr(1'b1, 2'd2, 8'h04);
        check_val("icw3_cascade", cascade, 8'h04);
        check_val("icw3_done", {7'd0, init_done}, 8'h01);
        wr(1'b1, 2'd3, 8'h03);
        check_val("ready_icw4_aeoi", {7'd0, aeoi}, 8'h00);

        // OCW1 then IMR read-back
        wr(1'b0, 2'd0, 8'hA5);
        check_val("ocw1_imr", imr, 8'hA5);
        rd(1'b1);
        check_val("rd_imr", rd_data, 8'hA5);
        check_val("rd_imr_vld", {7'd0, rd_vld}, 8'h01);
        idle();
        check_val("rd_vld_pulse", {7'd0, rd_vld}, 8'h00);
        check_val("rd_data_hold", rd_data, 8'hA5);

        // Write and read in the same cycle: read sees the old IMR
        @(negedge clk);
        wr_stb = 1'b1; wr_type = 1'b0; wr_nr = 2'd0; wr_data = 8'h3C;
        rd_stb = 1'b1; rd_a0 = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0; rd_stb = 1'b0;
        check_val("simul_rd_old", rd_data, 8'hA5);
        check_val("simul_imr_new", imr, 8'h3C);

        // OCW2 specific EOI level 3, then rotate + non-specific EOI
        wr(1'b0, 2'd1, 8'h63);
        check_val("ocw2_eoi_vld", {7'd0, eoi_vld}, 8'h01);
        check_val("ocw2_eoi_spec", {7'd0, eoi_spec}, 8'h01);
        check_val("ocw2_eoi_lvl", {5'd0, eoi_lvl}, 8'h03);
        check_val("ocw2_rot_0", {7'd0, rot_vld}, 8'h00);
        idle();
        check_val("ocw2_eoi_pulse", {7'd0, eoi_vld}, 8'h00);
        wr(1'b0, 2'd1, 8'hA0);
        check_val("ocw2b_eoi_vld", {7'd0, eoi_vld}, 8'h01);
        check_val("ocw2b_rot_vld", {7'd0, rot_vld}, 8'h01);
        check_val("ocw2b_spec", {7'd0, eoi_spec}, 8'h00);

        // IRR / ISR / poll read sources
        irr = 8'h11; isr = 8'h02; poll_word = 8'h85;
        rd(1'b0);
        check_val("rd_irr", rd_data, 8'h11);
        wr(1'b0, 2'd2, 8'h0B);
        rd(1'b0);
        check_val("rd_isr", rd_data, 8'h02);
        wr(1'b0, 2'd2, 8'h0C);
        rd(1'b0);
        check_val("rd_poll", rd_data, 8'h85);
        check_val("poll_ack", {7'd0, poll_ack}, 8'h01);
        rd(1'b0);
        check_val("rd_after_poll", rd_data, 8'h02);
        check_val("poll_ack_clr", {7'd0, poll_ack}, 8'h00);

        // Poll request written alongside a read applies only to the next read
        @(negedge clk);
        wr_stb = 1'b1; wr_type = 1'b0; wr_nr = 2'd2; wr_data = 8'h0C;
        rd_stb = 1'b1; rd_a0 = 1'b0;
        @(negedge clk);
        wr_stb = 1'b0; rd_stb = 1'b0;
        check_val("simul_poll_rd", rd_data, 8'h02);
        check_val("simul_poll_noack", {7'd0, poll_ack}, 8'h00);
        rd(1'b0);
        check_val("simul_poll_next", rd_data, 8'h85);

        // Special mask mode set
        wr(1'b0, 2'd2, 8'h68);
        check_val("ocw3_smm", {7'd0, smm}, 8'h01);

        // ICW1 restart mid-sequence keeps vector_base until a new ICW2
        wr(1'b1, 2'd0, 8'h13);
        check_val("restart_smm_clr", {7'd0, smm}, 8'h00);
        wr(1'b1, 2'd1, 8'h88);
        check_val("restart_vec", {3'd0, vector_base}, 8'h11);
        wr(1'b1, 2'd0, 8'h13);
        check_val("restart_vec_kept", {3'd0, vector_base}, 8'h11);
        check_val("restart_not_done", {7'd0, init_done}, 8'h00);
        wr(1'b1, 2'd1, 8'h30);
        check_val("restart_icw2", {3'd0, vector_base}, 8'h06);

        // Asynchronous reset mid-sequence
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_imr", imr, 8'hFF);
        check_val("arst_done", {7'd0, init_done}, 8'h00);
        check_val("arst_vec", {3'd0, vector_base}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wr(1'b1, 2'd1, 8'h48);
        check_val("post_rst_icw2_ign", {3'd0, vector_base}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
